// File: rtl/ysyx_22041412_seq_ctrl.sv
// ysyx_22041412_seq_ctrl: handshaked multi-cycle sequencer for the RV64 core.
// Owns the PC and the latched instruction, resolves branches/jumps, and emits
// the register-write and commit strobes for the external datapath.
// Optional feature: define YSYX_22041412_FETCH_TIMEOUT_EN to halt with err
// when a fetch is not answered within TIMEOUT cycles.
module ysyx_22041412_seq_ctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000),
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    output logic [31:0]     inst_q,
    input  logic [2:0]      inst_cls,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            lsu_req,
    input  logic            lsu_done,
    output logic            reg_wen,
    output logic [1:0]      wb_sel,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            commit,
    output logic            halted,
    output logic            err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JAL    = 3'd4;
    localparam logic [2:0] C_JALR   = 3'd5;
    localparam logic [2:0] C_EBREAK = 3'd6;
    localparam logic [2:0] C_ILL    = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [31:0]     inst_d;
    logic            taken_q, taken_d;
    logic            wen_q, wen_d;
    logic [1:0]      wb_sel_q, wb_sel_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic            br_cond;
    logic            exec_taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] exec_target;
    logic            fetch_timeout;

    // Branch condition, jump target and taken decision for the EXEC cycle.
    always_comb begin
        br_cond = 1'b0;
        case (func3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val <  rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
        jalr_sum    = rs1_val + imm;
        exec_target = (inst_cls == C_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm;
        exec_taken  = ((inst_cls == C_BRANCH) && br_cond) ||
                      (inst_cls == C_JAL) || (inst_cls == C_JALR);
    end

`ifdef YSYX_22041412_FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Fetch wait counter: held at zero outside FETCH so every entry starts fresh.
    always_comb begin
        to_cnt_d      = '0;
        if (state_q == S_FETCH) to_cnt_d = to_cnt_q + 1'b1;
        fetch_timeout = (state_q == S_FETCH) && (to_cnt_q == TO_W'(TIMEOUT - 1));
    end

    // Fetch wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign fetch_timeout = 1'b0;
`endif

    // Sequencer next-state and registered control decisions.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        inst_d   = inst_q;
        taken_d  = taken_q;
        wen_d    = wen_q;
        wb_sel_d = wb_sel_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (if_valid) begin
                    inst_d  = if_inst;
                    state_d = S_DECODE;
                end else if (fetch_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                taken_d  = exec_taken;
                target_d = exec_target;
                wen_d    = (inst_cls == C_ALU) || (inst_cls == C_LOAD) ||
                           (inst_cls == C_JAL) || (inst_cls == C_JALR);
                case (inst_cls)
                    C_LOAD:         wb_sel_d = 2'b01;
                    C_JAL, C_JALR:  wb_sel_d = 2'b10;
                    default:        wb_sel_d = 2'b00;
                endcase
                if (inst_cls == C_ILL) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (inst_cls == C_EBREAK) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (exec_taken && (exec_target[1:0] != 2'b00)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if ((inst_cls == C_LOAD) || (inst_cls == C_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:    if (lsu_done) state_d = S_WB;
            S_WB: begin
                pc_d    = npc;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            target_q <= '0;
            inst_q   <= '0;
            taken_q  <= 1'b0;
            wen_q    <= 1'b0;
            wb_sel_q <= 2'b00;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            inst_q   <= inst_d;
            taken_q  <= taken_d;
            wen_q    <= wen_d;
            wb_sel_q <= wb_sel_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign npc     = taken_q ? target_q : pc_q + XLEN'(4);
    assign pc      = pc_q;
    assign if_addr = pc_q;
    assign if_req  = (state_q == S_FETCH);
    assign lsu_req = (state_q == S_MEM);
    assign commit  = (state_q == S_WB);
    assign reg_wen = (state_q == S_WB) && wen_q;
    assign wb_sel  = wb_sel_q;
    assign halted  = halted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ysyx_22041412_seq_ctrl.sv
// Directed testbench for ysyx_22041412_seq_ctrl.
// Checks the fetch-wait timeout when YSYX_22041412_FETCH_TIMEOUT_EN is defined,
// otherwise checks that FETCH waits indefinitely.
module tb_ysyx_22041412_seq_ctrl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] inst_q;
    logic [2:0]  inst_cls;
    logic [2:0]  func3;
    logic [63:0] imm;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic        lsu_req;
    logic        lsu_done;
    logic        reg_wen;
    logic [1:0]  wb_sel;
    logic [63:0] pc;
    logic [63:0] npc;
    logic        commit;
    logic        halted;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_pc;

    ysyx_22041412_seq_ctrl #(
        .XLEN     (64),
        .RESET_PC (RST_PC),
        .TIMEOUT  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .inst_q   (inst_q),
        .inst_cls (inst_cls),
        .func3    (func3),
        .imm      (imm),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .lsu_req  (lsu_req),
        .lsu_done (lsu_done),
        .reg_wen  (reg_wen),
        .wb_sel   (wb_sel),
        .pc       (pc),
        .npc      (npc),
        .commit   (commit),
        .halted   (halted),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, check reset values, release and land in the first FETCH cycle.
    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        if_valid = 1'b0;
        lsu_done = 1'b0;
        #12;
        check({tag, ".rst.pc"},      pc,      RST_PC);
        check({tag, ".rst.npc"},     npc,     RST_PC + 64'd4);
        check({tag, ".rst.inst_q"},  {32'd0, inst_q}, 64'd0);
        check({tag, ".rst.if_req"},  {63'd0, if_req},  64'd0);
        check({tag, ".rst.lsu_req"}, {63'd0, lsu_req}, 64'd0);
        check({tag, ".rst.reg_wen"}, {63'd0, reg_wen}, 64'd0);
        check({tag, ".rst.commit"},  {63'd0, commit},  64'd0);
        check({tag, ".rst.wb_sel"},  {62'd0, wb_sel},  64'd0);
        check({tag, ".rst.halted"},  {63'd0, halted},  64'd0);
        check({tag, ".rst.err"},     {63'd0, err},     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, ".idle.if_req"}, {63'd0, if_req}, 64'd0);
        step();
        check({tag, ".fetch.if_req"}, {63'd0, if_req}, 64'd1);
        check({tag, ".fetch.addr"},   if_addr, RST_PC);
        exp_pc = RST_PC;
    endtask

    // Run one committing instruction starting in FETCH; ends in the next FETCH.
    task automatic run_instr(input string tag, input logic [2:0] cls, input logic [2:0] f3,
                             input logic [63:0] im, input logic [63:0] r1, input logic [63:0] r2,
                             input logic [31:0] inst, input int unsigned waits,
                             input int unsigned mem_n, input logic [63:0] exp_npc,
                             input logic exp_wen, input logic [1:0] exp_sel);
        inst_cls = cls; func3 = f3; imm = im; rs1_val = r1; rs2_val = r2;
        for (int unsigned i = 0; i < waits; i++) begin
            check($sformatf("%s.wait%0d.addr", tag, i), if_addr, exp_pc);
            step();
        end
        check({tag, ".if_req"}, {63'd0, if_req}, 64'd1);
        check({tag, ".if_addr"}, if_addr, exp_pc);
        if_inst  = inst;
        if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        if_inst  = 32'hDEAD_BEEF;
        check({tag, ".inst_q"}, {32'd0, inst_q}, {32'd0, inst});
        check({tag, ".dec.if_req"}, {63'd0, if_req}, 64'd0);
        step();
        check({tag, ".exec.lsu_req"}, {63'd0, lsu_req}, 64'd0);
        step();
        for (int unsigned i = 0; i < mem_n; i++) begin
            check($sformatf("%s.mem%0d.lsu_req", tag, i), {63'd0, lsu_req}, 64'd1);
            check($sformatf("%s.mem%0d.commit", tag, i), {63'd0, commit}, 64'd0);
            lsu_done = (i == mem_n - 1);
            step();
            lsu_done = 1'b0;
        end
        check({tag, ".wb.commit"},  {63'd0, commit},  64'd1);
        check({tag, ".wb.lsu_req"}, {63'd0, lsu_req}, 64'd0);
        check({tag, ".wb.npc"},     npc, exp_npc);
        check({tag, ".wb.reg_wen"}, {63'd0, reg_wen}, {63'd0, exp_wen});
        check({tag, ".wb.wb_sel"},  {62'd0, wb_sel},  {62'd0, exp_sel});
        step();
        check({tag, ".next.commit"},  {63'd0, commit},  64'd0);
        check({tag, ".next.reg_wen"}, {63'd0, reg_wen}, 64'd0);
        check({tag, ".next.pc"},      pc, exp_npc);
        check({tag, ".next.if_req"},  {63'd0, if_req}, 64'd1);
        check({tag, ".next.if_addr"}, if_addr, exp_npc);
        exp_pc = exp_npc;
    endtask

    // Run one instruction that must end in HALT straight out of EXEC.
    task automatic run_halt(input string tag, input logic [2:0] cls, input logic [63:0] im,
                            input logic [63:0] r1, input logic exp_halted, input logic exp_err);
        inst_cls = cls; func3 = 3'b000; imm = im; rs1_val = r1; rs2_val = 64'd0;
        if_inst  = 32'h0010_0073;
        if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        step();
        step();
        check({tag, ".commit"},  {63'd0, commit},  64'd0);
        check({tag, ".reg_wen"}, {63'd0, reg_wen}, 64'd0);
        check({tag, ".halted"},  {63'd0, halted},  {63'd0, exp_halted});
        check({tag, ".err"},     {63'd0, err},     {63'd0, exp_err});
        check({tag, ".pc"},      pc, exp_pc);
        if_valid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check($sformatf("%s.h%0d.if_req", tag, i), {63'd0, if_req}, 64'd0);
            check($sformatf("%s.h%0d.commit", tag, i), {63'd0, commit}, 64'd0);
        end
        if_valid = 1'b0;
        check({tag, ".pc_hold"}, pc, exp_pc);
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; lsu_done = 1'b0;
        inst_cls = '0; func3 = '0; imm = '0; rs1_val = '0; rs2_val = '0;
        exp_pc = RST_PC;

        do_reset("r0");
        run_instr("alu0", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0000_0013, 0, 0, 64'h8000_0004, 1'b1, 2'b00);
        run_instr("alu1", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0010_0093, 2, 0, 64'h8000_0008, 1'b1, 2'b00);
        run_instr("alu2", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0020_0113, 0, 0, 64'h8000_000C, 1'b1, 2'b00);
        run_instr("alu3", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0030_0193, 1, 0, 64'h8000_0010, 1'b1, 2'b00);
        run_instr("blt",  3'd3, 3'b100, -64'sd8, -64'sd1, 64'd1, 32'hFE10_CCE3, 0, 0, 64'h8000_0008, 1'b0, 2'b00);
        run_instr("alu4", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0000_0013, 0, 0, 64'h8000_000C, 1'b1, 2'b00);
        run_instr("alu5", 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 32'h0000_0013, 0, 0, 64'h8000_0010, 1'b1, 2'b00);
        run_instr("bltu", 3'd3, 3'b110, -64'sd8, -64'sd1, 64'd1, 32'hFE10_ECE3, 0, 0, 64'h8000_0014, 1'b0, 2'b00);
        run_instr("b010", 3'd3, 3'b010, -64'sd8, 64'd5, 64'd5, 32'hFE10_ACE3, 0, 0, 64'h8000_0018, 1'b0, 2'b00);
        run_instr("bne",  3'd3, 3'b001, 64'd8, -64'sd1, 64'd1, 32'h0010_9463, 0, 0, 64'h8000_0020, 1'b0, 2'b00);
        run_instr("bge",  3'd3, 3'b101, 64'd8, -64'sd1, 64'd1, 32'h0010_D463, 0, 0, 64'h8000_0024, 1'b0, 2'b00);
        run_instr("beq",  3'd3, 3'b000, -64'sd4, 64'd5, 64'd5, 32'hFE10_8EE3, 0, 0, 64'h8000_0020, 1'b0, 2'b00);
        run_instr("bgeu", 3'd3, 3'b111, 64'd8, -64'sd1, 64'd1, 32'h0010_F463, 0, 0, 64'h8000_0028, 1'b0, 2'b00);
        run_instr("jal",  3'd4, 3'd0, 64'h100, 64'd0, 64'd0, 32'h1000_00EF, 0, 0, 64'h8000_0128, 1'b1, 2'b10);
        run_instr("jalr", 3'd5, 3'd0, 64'd0, 64'h8000_1001, 64'd0, 32'h0000_80E7, 0, 0, 64'h8000_1000, 1'b1, 2'b10);
        run_instr("ld3",  3'd1, 3'b011, 64'd0, 64'd0, 64'd0, 32'h0000_3083, 0, 3, 64'h8000_1004, 1'b1, 2'b01);
        run_instr("sd3",  3'd2, 3'b011, 64'd0, 64'd0, 64'd0, 32'h0010_3023, 0, 3, 64'h8000_1008, 1'b0, 2'b00);
        run_instr("ld1",  3'd1, 3'b011, 64'd0, 64'd0, 64'd0, 32'h0000_3083, 0, 1, 64'h8000_100C, 1'b1, 2'b01);
        run_halt("jalr_mis", 3'd5, 64'd0, 64'h8000_1003, 1'b0, 1'b1);

        do_reset("r1");
        run_halt("ebreak", 3'd6, 64'd0, 64'd0, 1'b1, 1'b0);

        do_reset("r2");
        run_halt("illegal", 3'd7, 64'd0, 64'd0, 1'b0, 1'b1);

        // Reset asserted while a load waits in MEM must drop the request at once.
        do_reset("r3");
        inst_cls = 3'd1; if_inst = 32'h0000_3083; if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        step();
        step();
        check("abort.lsu_req_before", {63'd0, lsu_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort.lsu_req", {63'd0, lsu_req}, 64'd0);
        check("abort.pc",      pc, RST_PC);
        check("abort.if_req",  {63'd0, if_req}, 64'd0);

        do_reset("r4");
`ifdef YSYX_22041412_FETCH_TIMEOUT_EN
        for (int unsigned i = 0; i < 4; i++) begin
            check($sformatf("to.c%0d.if_req", i), {63'd0, if_req}, 64'd1);
            check($sformatf("to.c%0d.err", i),    {63'd0, err},    64'd0);
            step();
        end
        check("to.err",    {63'd0, err},    64'd1);
        check("to.if_req", {63'd0, if_req}, 64'd0);
        check("to.halted", {63'd0, halted}, 64'd0);
`else
        for (int unsigned i = 0; i < 100; i++) begin
            check($sformatf("nto.c%0d.if_req", i), {63'd0, if_req}, 64'd1);
            check($sformatf("nto.c%0d.err", i),    {63'd0, err},    64'd0);
            step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
